// File: rtl/toggle_hs_rx.sv
// Two-phase toggle handshake receiver. It synchronises req_t, captures data_in into
// a show-ahead FIFO and returns ack_t, and delays the ack while the FIFO is full.
//
// state | meaning
// IDLE  | no request waiting on a full FIFO
// STALL | request pending but FIFO full; ack withheld until space frees
module toggle_hs_rx #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       rst,
    input  logic                       req_t,
    input  logic [DW-1:0]              data_in,
    output logic                       ack_t,
    output logic [DW-1:0]              out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH)+1-1:0] count,
    output logic                       stalled
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          req_s1, req_s2, req_seen;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          pending, full, do_push, do_pop;

    // full is judged on the pre-edge count, so a pop never makes room for the same-edge push
    assign pending   = req_s2 != req_seen;
    assign full      = count == FULL_CNT;
    assign do_push   = pending && !full;
    assign out_valid = count != '0;
    assign do_pop    = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    assign stalled   = state == STALL;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending && full) state_nxt = STALL;
            STALL:   if (do_push)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state    <= IDLE;
            req_s1   <= 1'b0;
            req_s2   <= 1'b0;
            req_seen <= 1'b0;
            ack_t    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state  <= state_nxt;
            req_s1 <= req_t;
            req_s2 <= req_s1;
            if (do_push) begin
                req_seen <= req_s2;
                ack_t    <= ~ack_t;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is not reset; out_data is only meaningful while out_valid is high
    always_ff @(posedge Clk) begin
        if (!rst && do_push) mem[wr_ptr] <= data_in;
    end
endmodule

// File: doc/toggle_hs_rx.md
TOGGLE_HS_RX -- requirements
Module: toggle_hs_rx

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries; power of two, 2..16.
REQ-003 SHALL have port Clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising Clk.
REQ-005 SHALL have port req_t  input  1  two-phase request toggle from sender; each transition equals one word offered.
REQ-006 SHALL have port data_in  input  DW  word offered by sender; held stable from req_t transition until ack_t transition.
REQ-007 SHALL have port ack_t  output  1  two-phase acknowledge toggle; one transition per word captured.
REQ-008 SHALL have port out_data  output  DW  head-of-FIFO word, show-ahead.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head word when out_valid high.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port stalled  output  1  high while a request is pending but FIFO is full.

Function
REQ-013 SHALL pass req_t through a two-stage synchroniser (req_s1, req_s2) clocked by Clk.
REQ-014 SHALL keep register req_seen; request pending defined as req_s2 != req_seen.
REQ-015 SHALL implement FSM states IDLE and STALL; STALL entered when pending and FIFO full, left to IDLE on the edge the word is captured.
REQ-016 SHALL capture on a rising edge where pending and count < DEPTH: write data_in at write pointer, req_seen <= req_s2, ack_t <= ~ack_t, all on the same edge.
REQ-017 SHALL give latency: req_t transition sampled at edge N -> req_s2 updated at edge N+1 -> capture and ack_t transition at edge N+2 when FIFO not full.
REQ-018 SHALL capture at most one word per request transition; a second req_t transition before ack_t is a sender protocol error and need not be detected.
REQ-019 SHALL pop on a rising edge where out_valid and out_ready are both high, advancing read pointer.
REQ-020 SHALL evaluate full from count before the edge: push and pop on same edge while full SHALL pop only; push occurs next edge (STALL lasts one more cycle).
REQ-021 SHALL on same-edge push and pop while 0 < count < DEPTH leave count unchanged and perform both.
REQ-022 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer combinationally; out_data value is don't-care when out_valid low.
REQ-023 SHALL wrap read and write pointers modulo DEPTH without gaps.
REQ-024 SHALL ignore out_ready when out_valid low (no underflow, count never below 0).
REQ-025 SHALL never exceed count = DEPTH; no word is lost or overwritten; back-pressure is via delayed ack_t only.
REQ-026 SHALL drive stalled high exactly while FSM is in STALL.

Reset
REQ-027 SHALL on rst set ack_t=0, req_s1=0, req_s2=0, req_seen=0, pointers=0, count=0, out_valid=0, stalled=0, FSM=IDLE; FIFO storage contents need not be cleared.
REQ-028 SHALL give rst priority over capture and pop on the same edge; a word in flight at reset is discarded and not acknowledged.
REQ-029 SHALL treat req_t=1 after reset release as a pending request (captured at third edge after release), since req_seen resets to 0.

Verification
REQ-030 Single word: after reset, data_in=8'hA5, req_t 0->1 before edge N, out_ready=0 -> ack_t 0->1 after edge N+2, count=1, out_valid=1, out_data=8'hA5.
REQ-031 Burst to full: four handshakes 8'h01..8'h04 with out_ready=0, then fifth req_t toggle with 8'h05 -> ack_t holds, stalled=1, count=4; assert out_ready one cycle -> pop 8'h01, 8'h05 captured next edge, ack_t toggles, stalled=0.
REQ-032 Simultaneous push/pop at count=2 -> count stays 2, order preserved, drained sequence 01,02,03 with no duplicate.
REQ-033 Drain and empty: pop all with out_ready held high -> out_valid falls after last word, count=0, extra out_ready cycles change nothing.
REQ-034 Reset mid-operation: rst asserted one cycle while request pending and count=3 -> count=0, out_valid=0, ack_t=0 next edge; with req_t still 1, word captured third edge after release.
REQ-035 Pointer wrap: 10 handshakes with continuous consumption -> all 10 words delivered in order, count never exceeds DEPTH.
